// File: rtl/jt12_lfo_ctrl_if.sv
// Write bus for the LFO register controller: valid/ready handshake carrying
// an 8-bit address and an 8-bit data byte.
interface jt12_lfo_ctrl_if;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/jt12_lfo_ctrl.sv
// jt12_lfo_ctrl: register-side controller for the YM2612 LFO counter.
// Takes CPU writes, decodes the LFO register {en, freq}, derives the
// once-per-sample zero tick from slot clock enables, and applies new LFO
// settings only at a sample boundary.
//
// Build option: define JT12_LFO_WRMERGE_EN to keep the write port open while
// a setting is waiting (last LFO write before the boundary wins).
//
// state | meaning
// IDLE  | no setting waiting; writes accepted
// PEND  | decoded LFO write held until the next zero tick
// APPLY | one clk: pending setting is loaded into lfo_en/lfo_freq
module jt12_lfo_ctrl #(
    parameter int         SLOTS    = 24,
    parameter logic [7:0] LFO_ADDR = 8'h22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    jt12_lfo_ctrl_if.slave   wr,
    output logic             zero,
    output logic             lfo_en,
    output logic [2:0]       lfo_freq,
    output logic             lfo_rst,
    output logic             pending
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        APPLY = 2'd2
    } state_t;

    localparam logic [5:0] LAST_SLOT = 6'(SLOTS - 1);

    state_t     state;
    state_t     state_nx;
    logic [5:0] cnt;
    logic [3:0] pend_reg;
    logic       xfer;
    logic       lfo_wr;
    logic       unused_hi;

    assign xfer      = wr.wr_valid && wr.wr_ready;
    assign lfo_wr    = xfer && (wr.wr_addr == LFO_ADDR);
    assign unused_hi = ^wr.wr_data[7:4];

    // Slot counter and the registered end-of-sample tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 6'd0;
            zero <= 1'b0;
        end else begin
            zero <= cen && (cnt == LAST_SLOT);
            if (cen)
                cnt <= (cnt == LAST_SLOT) ? 6'd0 : cnt + 6'd1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (lfo_wr) state_nx = PEND;
            PEND:    if (zero)   state_nx = APPLY;
`ifdef JT12_LFO_WRMERGE_EN
            APPLY:   state_nx = lfo_wr ? PEND : IDLE;
`else
            APPLY:   state_nx = IDLE;
`endif
            default: state_nx = IDLE;
        endcase
    end

    // State-decoded outputs; lfo_rst flags an enable edge on the apply clk.
    always_comb begin
        wr.wr_ready = 1'b1;
        pending     = 1'b0;
        lfo_rst     = 1'b0;
        case (state)
            PEND: begin
                pending = 1'b1;
`ifndef JT12_LFO_WRMERGE_EN
                wr.wr_ready = 1'b0;
`endif
            end
            APPLY: begin
                lfo_rst = (pend_reg[3] != lfo_en);
`ifndef JT12_LFO_WRMERGE_EN
                wr.wr_ready = 1'b0;
`endif
            end
            default: ;
        endcase
    end

    // Pending-setting latch and applied LFO settings. An LFO write in APPLY
    // (merge build) refills pend_reg while the old value is being applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_reg <= 4'd0;
            lfo_en   <= 1'b0;
            lfo_freq <= 3'd0;
        end else begin
            if (lfo_wr)
                pend_reg <= wr.wr_data[3:0];
            if (state == APPLY) begin
                lfo_en   <= pend_reg[3];
                lfo_freq <= pend_reg[2:0];
            end
        end
    end

endmodule

// File: tb/tb_jt12_lfo_ctrl.sv
// Self-checking bench for jt12_lfo_ctrl: directed scenarios plus a randomized
// run compared cycle by cycle against a sample-boundary reference model.
module tb_jt12_lfo_ctrl;

    localparam int SLOTS = 24;
`ifdef JT12_LFO_WRMERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic       zero;
    logic       lfo_en;
    logic [2:0] lfo_freq;
    logic       lfo_rst;
    logic       pending;

    int n_tests = 0;
    int n_fail  = 0;

    jt12_lfo_ctrl_if bus ();

    jt12_lfo_ctrl #(.SLOTS(SLOTS), .LFO_ADDR(8'h22)) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .wr       (bus),
        .zero     (zero),
        .lfo_en   (lfo_en),
        .lfo_freq (lfo_freq),
        .lfo_rst  (lfo_rst),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst          = 1'b1;
        cen          = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = 8'h00;
        bus.wr_data  = 8'h00;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Holds a write until it is accepted; waits = edges spent stalled.
    task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                            output int waits, output bit ok);
        bit r;
        ok           = 1'b0;
        waits        = 0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        for (int i = 0; i < 64; i++) begin
            r = bus.wr_ready;
            tick;
            if (r) begin
                ok = 1'b1;
                break;
            end
            waits++;
        end
        bus.wr_valid = 1'b0;
    endtask

    // Runs until the zero tick, then two more clks; gathers observations.
    task automatic run_to_apply(output int n_rst, output bit pend_held,
                                output bit ready_low, output int cyc, output bit ok);
        n_rst     = 0;
        pend_held = 1'b1;
        ready_low = 1'b0;
        cyc       = 0;
        ok        = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.wr_ready !== 1'b1) ready_low = 1'b1;
            if (lfo_rst === 1'b1) n_rst++;
            if (zero === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (pending !== 1'b1) pend_held = 1'b0;
            tick;
            cyc++;
        end
        if (ok) begin
            if (pending !== 1'b1) pend_held = 1'b0;
            for (int j = 0; j < 2; j++) begin
                tick;
                if (lfo_rst === 1'b1) n_rst++;
                if (bus.wr_ready !== 1'b1) ready_low = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        int pulses;
        int first_k;
        int last_k;
        bit seen;
        do_reset;
        n_tests++;
        if ({zero, lfo_en, lfo_freq, lfo_rst, pending, bus.wr_ready} !== 8'b0000_0001) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 00000001",
                     {zero, lfo_en, lfo_freq, lfo_rst, pending, bus.wr_ready});
        end
        pulses = 0; first_k = -1; last_k = -1; seen = 1'b0;
        for (int k = 0; k < 48; k++) begin
            cen = 1'b1;
            tick;
            n_tests++;
            if (zero !== ((k % SLOTS) == SLOTS - 1)) begin
                n_fail++;
                $display("FAIL zero_after_cen%0d: got %b want %b", k, zero, (k % SLOTS) == SLOTS - 1);
            end
            if (!seen) begin
                n_tests++;
                if ({lfo_en, lfo_freq, lfo_rst, pending} !== 6'b0) begin
                    n_fail++;
                    $display("FAIL quiet_before_zero cen%0d: got %b want 000000", k,
                             {lfo_en, lfo_freq, lfo_rst, pending});
                end
            end
            if (zero === 1'b1) begin
                pulses++;
                if (first_k < 0) first_k = k;
                last_k = k;
                seen = 1'b1;
            end
            cen = 1'b0;
            tick;
            n_tests++;
            if (zero !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_width cen%0d: got %b want 0", k, zero);
            end
        end
        n_tests++;
        if (pulses != 2 || (last_k - first_k) != SLOTS) begin
            n_fail++;
            $display("FAIL zero_count: got %0d pulses spacing %0d want 2 pulses spacing %0d",
                     pulses, last_k - first_k, SLOTS);
        end
    endtask

    task automatic test_enable_on;
        int waits, n_rst, cyc;
        bit ok, held, rlow;
        do_reset;
        cen = 1'b1;
        do_write(8'h22, 8'h0D, waits, ok);
        n_tests++;
        if (!ok || waits != 0 || pending !== 1'b1 || bus.wr_ready !== MERGE) begin
            n_fail++;
            $display("FAIL en_on_accept: ok=%0d waits=%0d pending=%b ready=%b want 1 0 1 %b",
                     ok, waits, pending, bus.wr_ready, MERGE);
        end
        run_to_apply(n_rst, held, rlow, cyc, ok);
        n_tests++;
        if (!ok || !held || n_rst != 1 || lfo_en !== 1'b1 || lfo_freq !== 3'd5 || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL en_on_apply: ok=%0d held=%0d rst=%0d en=%b freq=%0d pend=%b want 1 1 1 1 5 0",
                     ok, held, n_rst, lfo_en, lfo_freq, pending);
        end
    endtask

    task automatic test_freq_and_disable;
        int waits, n_rst, cyc;
        bit ok, held, rlow;
        do_write(8'h22, 8'h0B, waits, ok);
        run_to_apply(n_rst, held, rlow, cyc, ok);
        n_tests++;
        if (!ok || n_rst != 0 || lfo_en !== 1'b1 || lfo_freq !== 3'd3) begin
            n_fail++;
            $display("FAIL freq_change: ok=%0d rst=%0d en=%b freq=%0d want 1 0 1 3",
                     ok, n_rst, lfo_en, lfo_freq);
        end
        do_write(8'h22, 8'h03, waits, ok);
        run_to_apply(n_rst, held, rlow, cyc, ok);
        n_tests++;
        if (!ok || n_rst != 1 || lfo_en !== 1'b0 || lfo_freq !== 3'd3) begin
            n_fail++;
            $display("FAIL disable: ok=%0d rst=%0d en=%b freq=%0d want 1 1 0 3",
                     ok, n_rst, lfo_en, lfo_freq);
        end
    endtask

    task automatic test_other_addr;
        int waits;
        bit ok;
        bit bad;
        do_write(8'h30, 8'hFF, waits, ok);
        n_tests++;
        if (!ok || waits != 0) begin
            n_fail++;
            $display("FAIL other_accept: ok=%0d waits=%0d want 1 0", ok, waits);
        end
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (pending !== 1'b0 || lfo_en !== 1'b0 || lfo_freq !== 3'd3 || lfo_rst !== 1'b0) bad = 1'b1;
            tick;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL other_dropped: pend=%b en=%b freq=%0d want 0 0 3", pending, lfo_en, lfo_freq);
        end
    endtask

    task automatic test_write_on_zero;
        int waits, n_rst, cyc;
        bit ok, held, rlow;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (zero === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wz_find_zero: got no zero want zero within 100 clks");
        end
        do_write(8'h22, 8'h0F, waits, ok);
        n_tests++;
        if (!ok || waits != 0 || pending !== 1'b1) begin
            n_fail++;
            $display("FAIL wz_accept: ok=%0d waits=%0d pend=%b want 1 0 1", ok, waits, pending);
        end
        run_to_apply(n_rst, held, rlow, cyc, ok);
        n_tests++;
        if (!ok || !held || cyc != SLOTS - 1 || n_rst != 1 || lfo_en !== 1'b1 || lfo_freq !== 3'd7) begin
            n_fail++;
            $display("FAIL wz_next_zero: ok=%0d held=%0d cyc=%0d rst=%0d en=%b freq=%0d want 1 1 %0d 1 1 7",
                     ok, held, cyc, n_rst, lfo_en, lfo_freq, SLOTS - 1);
        end
    endtask

    task automatic test_reset_in_pend;
        int waits, n_rst;
        bit ok, bad;
        do_write(8'h22, 8'h09, waits, ok);
        tick;
        tick;
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({zero, lfo_en, lfo_freq, lfo_rst, pending, bus.wr_ready} !== 8'b0000_0001) begin
            n_fail++;
            $display("FAIL rst_mid_pend: got %b want 00000001",
                     {zero, lfo_en, lfo_freq, lfo_rst, pending, bus.wr_ready});
        end
        tick;
        rst = 1'b0;
        n_rst = 0;
        bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick;
            if (lfo_rst === 1'b1) n_rst++;
            if (lfo_en !== 1'b0 || lfo_freq !== 3'd0 || pending !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad || n_rst != 0) begin
            n_fail++;
            $display("FAIL rst_discard: bad=%0d rst_pulses=%0d want 0 0", bad, n_rst);
        end
    endtask

`ifdef JT12_LFO_WRMERGE_EN
    task automatic test_merge;
        int w1, w2, n_rst, cyc;
        bit ok1, ok2, ok, held, rlow;
        do_reset;
        cen = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (zero === 1'b1) break;
            tick;
        end
        do_write(8'h22, 8'h09, w1, ok1);
        tick;
        do_write(8'h22, 8'h0E, w2, ok2);
        run_to_apply(n_rst, held, rlow, cyc, ok);
        n_tests++;
        if (!ok1 || !ok2 || w1 != 0 || w2 != 0 || rlow || !ok || lfo_en !== 1'b1 ||
            lfo_freq !== 3'd6 || n_rst != 1) begin
            n_fail++;
            $display("FAIL merge: w=%0d/%0d rlow=%0d en=%b freq=%0d rst=%0d want 0/0 0 1 6 1",
                     w1, w2, rlow, lfo_en, lfo_freq, n_rst);
        end
    endtask
`endif

    // Reference model: counts cens per sample; a decoded LFO write is held
    // until the first zero tick that is visible while it is waiting, then
    // lands one clk later, with lfo_rst on that in-between clk if en flips.
    task automatic test_random;
        int   cc;
        bit   m_zero, m_pend, m_apply, m_en, m_ready, m_rst;
        logic [2:0] m_freq;
        logic [3:0] m_pval, m_aval;
        bit   c, v, lfo;
        logic [7:0] a, d;
        bit   n_zero, n_pend, n_apply, n_en;
        logic [2:0] n_freq;
        logic [3:0] n_pval, n_aval;
        logic [7:0] got, want;
        do_reset;
        cc = 0;
        m_zero = 0; m_pend = 0; m_apply = 0; m_en = 0; m_freq = 3'd0;
        m_pval = 4'd0; m_aval = 4'd0;
        for (int i = 0; i < 3000; i++) begin
            c = ((i % 700) >= 300 && (i % 700) < 380) ? 1'b0 : 1'($urandom_range(0, 1));
            v = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 1) == 1) ? 8'h22 : 8'($urandom);
            d = 8'($urandom);
            cen = c; bus.wr_valid = v; bus.wr_addr = a; bus.wr_data = d;

            m_ready = MERGE || !(m_pend || m_apply);
            lfo     = v && m_ready && (a == 8'h22);
            n_zero  = c && (cc == SLOTS - 1);
            if (c) cc = (cc + 1) % SLOTS;
            n_en = m_en; n_freq = m_freq;
            if (m_apply) begin
                n_en   = m_aval[3];
                n_freq = m_aval[2:0];
            end
            n_pend = m_pend; n_apply = 1'b0; n_pval = m_pval; n_aval = m_aval;
            if (m_pend) begin
                if (lfo) n_pval = d[3:0];
                if (m_zero) begin
                    n_pend  = 1'b0;
                    n_apply = 1'b1;
                    n_aval  = n_pval;
                end
            end else if (lfo) begin
                n_pend = 1'b1;
                n_pval = d[3:0];
            end

            tick;
            m_zero = n_zero; m_pend = n_pend; m_apply = n_apply; m_en = n_en;
            m_freq = n_freq; m_pval = n_pval; m_aval = n_aval;
            m_ready = MERGE || !(m_pend || m_apply);
            m_rst   = m_apply && (m_aval[3] != m_en);

            got  = {zero, lfo_en, lfo_freq, lfo_rst, pending, bus.wr_ready};
            want = {m_zero, m_en, m_freq, m_rst, m_pend, m_ready};
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL random cyc%0d {zero,en,freq,rst,pend,ready}: got %b want %b", i, got, want);
            end
        end
        cen = 1'b0;
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_addr  = 8'h00;
        bus.wr_data  = 8'h00;
        test_reset;
        test_enable_on;
        test_freq_and_disable;
        test_other_addr;
        test_write_on_zero;
        test_reset_in_pend;
`ifdef JT12_LFO_WRMERGE_EN
        test_merge;
`endif
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
